// File: rtl/vmem_map_ram_if.sv
// Access bus of the virtual-memory map stage RAM: request fields from the
// map-address mux, registered read data and status back to the caller.
interface vmem_map_ram_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 24
);
  logic [ADDR_WIDTH-1:0] adr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  rd_en;
  logic                  wr_en;
  logic                  clear;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rdata_valid;
  logic                  busy;
  logic                  parity_err;

  modport master (
    output adr, wdata, rd_en, wr_en, clear,
    input  rdata, rdata_valid, busy, parity_err
  );

  modport slave (
    input  adr, wdata, rd_en, wr_en, clear,
    output rdata, rdata_valid, busy, parity_err
  );
endinterface

// File: rtl/vmem_map_ram.sv
// Parametrised map-stage RAM with read-before-write access and a clear sweeper.
// Optional per-entry even parity is enabled by defining VMEM_MAP_PARITY_EN.
module vmem_map_ram #(
  parameter int                    ADDR_WIDTH = 10,
  parameter int                    DATA_WIDTH = 24,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic           clk,
  input  logic           reset,
  vmem_map_ram_if.slave  bus
);
  localparam int DEPTH = 2**ADDR_WIDTH;

  typedef enum logic {SWEEP, IDLE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rdata_valid_q;
  logic                  busy_q;
  logic                  access;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_adr;
  logic [DATA_WIDTH-1:0] mem_wd;

  // clear wins over a same-cycle access, so the access is dropped entirely
  assign access  = (state == IDLE) && !bus.clear && (bus.rd_en || bus.wr_en);
  assign mem_we  = (state == SWEEP) || (access && bus.wr_en);
  assign mem_adr = (state == SWEEP) ? cnt : bus.adr;
  assign mem_wd  = (state == SWEEP) ? INIT_VALUE : bus.wdata;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_adr] <= mem_wd;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= SWEEP;
      cnt           <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      busy_q        <= 1'b1;
    end else begin
      rdata_valid_q <= 1'b0;
      case (state)
        SWEEP: begin
          cnt <= cnt + ADDR_WIDTH'(1);
          if (cnt == '1) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        IDLE: begin
          if (bus.clear) begin
            state  <= SWEEP;
            cnt    <= '0;
            busy_q <= 1'b1;
          end else if (access) begin
            rdata_q       <= mem[bus.adr];
            rdata_valid_q <= 1'b1;
          end
        end
        default: state <= SWEEP;
      endcase
    end
  end

  assign bus.rdata       = rdata_q;
  assign bus.rdata_valid = rdata_valid_q;
  assign bus.busy        = busy_q;

`ifdef VMEM_MAP_PARITY_EN
  logic par_mem [DEPTH];
  logic parity_err_q;

  always_ff @(posedge clk) begin
    if (mem_we) par_mem[mem_adr] <= ^mem_wd;
  end

  // flag is meaningful only alongside rdata_valid, so it drops every other cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) parity_err_q <= 1'b0;
    else        parity_err_q <= access && (par_mem[bus.adr] != ^mem[bus.adr]);
  end

  assign bus.parity_err = parity_err_q;
`else
  assign bus.parity_err = 1'b0;
`endif
endmodule
